// File: rtl/ctr_keystream_ctrl.sv
// ctr_keystream_ctrl: CTR-mode sequencer feeding a cipher core and XORing its keystream onto a word stream
module ctr_keystream_ctrl #(
    parameter int WORDS      = 4,
    parameter int WORD_SIZE  = 32,
    localparam int BLOCK_SIZE = WORDS * WORD_SIZE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BLOCK_SIZE-1:0] ctr_block,
    output logic                  ctr_increment,
    output logic                  aes_start,
    output logic [BLOCK_SIZE-1:0] aes_in,
    input  logic                  aes_done,
    input  logic [BLOCK_SIZE-1:0] aes_out,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_SIZE-1:0]  in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_SIZE-1:0]  out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic [31:0]           block_count
);
    localparam int IW = WORDS > 1 ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, STREAM, REFILL} state_t;

    state_t                state, state_nx;
    logic [IW-1:0]         idx, idx_nx;
    logic [BLOCK_SIZE-1:0] ks;
    logic [WORD_SIZE-1:0]  ks_word;
    logic                  xfer, issue, capture;

    assign xfer    = state == STREAM && in_valid && out_ready;
    assign issue   = (state == IDLE && in_valid) || state == REFILL;
    assign capture = state == WAIT && aes_done;
    assign ks_word = ks[BLOCK_SIZE-1-int'(idx)*WORD_SIZE -: WORD_SIZE];

    assign in_ready  = state == STREAM && out_ready;
    assign out_valid = state == STREAM && in_valid;
    assign out_data  = in_data ^ ks_word;
    assign out_last  = in_last;
    assign busy      = state != IDLE;

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        case (state)
            IDLE:   state_nx = in_valid ? WAIT : IDLE;
            WAIT:   if (aes_done) begin
                        state_nx = STREAM;
                        idx_nx   = '0;
                    end
            STREAM: if (xfer) begin
                        state_nx = in_last ? IDLE : (idx == IW'(WORDS-1) ? REFILL : STREAM);
                        idx_nx   = (in_last || idx == IW'(WORDS-1)) ? '0 : idx + IW'(1);
                    end
            default: state_nx = WAIT;
        endcase
    end

    // RAM increments one cycle after capture, well before REFILL can latch ctr_block
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            idx           <= '0;
            ks            <= '0;
            aes_in        <= '0;
            block_count   <= '0;
            ctr_increment <= 1'b0;
            aes_start     <= 1'b0;
        end else begin
            state         <= state_nx;
            idx           <= idx_nx;
            aes_start     <= issue;
            ctr_increment <= capture;
            if (issue)
                aes_in <= ctr_block;
            if (capture) begin
                ks          <= aes_out;
                block_count <= block_count + 32'd1;
            end
        end
    end
endmodule

// File: doc/ctr_keystream_ctrl.md
Name: ctr_keystream_ctrl

Overview:
- CTR-mode sequencer that sits directly downstream of the key/counter RAM.
- Takes the stored counter block and issues it to the block-cipher core with a start/done handshake.
- Pulses the RAM's increment input once per consumed keystream block.
- XORs the keystream, one word at a time, onto a valid/ready data stream.

Parameters:
- WORDS, 4, words per cipher block.
- WORD_SIZE, 32, bits per data word; block width BLOCK_SIZE = WORDS*WORD_SIZE.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low (asserted when 0)
- ctr_block  in  BLOCK_SIZE  counter block from RAM; word 0 in the MSBs
- ctr_increment  out  1  one-cycle pulse to the RAM increment input
- aes_start  out  1  one-cycle start pulse to the cipher core
- aes_in  out  BLOCK_SIZE  registered counter block presented to the core
- aes_done  in  1  core result valid (single-cycle pulse)
- aes_out  in  BLOCK_SIZE  core result; word 0 in the MSBs
- in_valid / in_ready  in / out  1  input handshake
- in_data  in  WORD_SIZE  plaintext/ciphertext word
- in_last  in  1  last word of the message
- out_valid / out_ready  out / in  1  output handshake
- out_data  out  WORD_SIZE  in_data XOR keystream word
- out_last  out  1  copy of in_last
- busy  out  1  high in any state other than IDLE
- block_count  out  32  keystream blocks generated since reset (wraps at 2^32)

Behaviour:
- Reset (rst==0 at posedge):
  - state=IDLE, idx=0, ks=0, aes_in=0, block_count=0.
  - ctr_increment=0, aes_start=0.
  - out_valid=0, in_ready=0.
  - Reset mid-operation abandons any in-flight block; a late aes_done is then ignored.
- IDLE:
  - in_ready=0, out_valid=0.
  - When in_valid=1: latch aes_in<=ctr_block, assert aes_start for exactly the next cycle, go to WAIT.
- WAIT:
  - Hold aes_in; aes_start=0 after its single cycle.
  - On aes_done: ks<=aes_out, idx<=0, block_count+=1, ctr_increment=1 for exactly the following cycle, go to STREAM.
  - aes_done in any other state is ignored.
- STREAM (combinational passthrough, zero added latency):
  - out_valid=in_valid, in_ready=out_ready.
  - out_data = in_data ^ ks word idx, where word idx = ks[BLOCK_SIZE-1-idx*WORD_SIZE -: WORD_SIZE].
  - out_last=in_last.
- Transfer = in_valid & out_ready in STREAM:
  - in_last=1 → go to IDLE, idx=0; remaining keystream is discarded and the counter is not rewound.
  - else if idx==WORDS-1 → go to REFILL.
  - else idx+=1.
- REFILL:
  - Identical to IDLE's issue step, taken unconditionally: latch ctr_block (already incremented by the RAM), pulse aes_start, go to WAIT.
  - in_ready=0 until the new keystream is captured.
- Word ordering:
  - Keystream word 0 is the first word consumed.
  - This matches the RAM's reversed-word storage, so no reordering is performed here.
- Increment timing:
  - ctr_increment is high for one cycle, one cycle after aes_done.
  - ctr_block must reflect the increment at least one cycle before REFILL latches it; the state path guarantees ≥1 cycle.
- Firmware must not write the RAM while busy=1; this block does not arbitrate.
- WORDS=1: every non-last transfer goes to REFILL.
- Backpressure: out_ready=0 holds in_ready=0; idx and ks are unchanged.

Test Plan:
- Stub core returns aes_out=~aes_in, 5 cycles after start. ctr_block=0x00000000_00000000_00000000_00000001. Send 4 words of 0 with in_last on word 4:
  - out_data=0xFFFFFFFF,0xFFFFFFFF,0xFFFFFFFF,0xFFFFFFFE.
  - One ctr_increment pulse; block_count=1; ends in IDLE.
- Same setup, 6-word message:
  - Second keystream block is computed from counter ...0002; words 5–6 = 0xFFFFFFFF,0xFFFFFFFF.
  - Two increment pulses; in_ready=0 during REFILL/WAIT.
- Hold out_ready=0 for 3 cycles mid-block:
  - in_ready=0 for those cycles; no word is skipped or duplicated; idx is unchanged.
- in_last on word 2:
  - Returns to IDLE; the next message starts a fresh block from the incremented counter (keystream word 0 = ~ctr word 0).
- Assert rst=0 during WAIT, then inject aes_done after rst=1:
  - All outputs are at their reset values; aes_done is ignored; no ctr_increment pulse.
- Pulse aes_done spuriously in IDLE:
  - No state change; block_count and ks are unchanged.
